// File: rtl/amber128_uart_tx_arb.sv
// Line-locked two-requester arbiter in front of a single UART transmitter.
// An owner keeps the UART until it sends EOL_CHAR or idles for IDLE_TIMEOUT cycles.
module amber128_uart_tx_arb #(
  parameter int unsigned IDLE_TIMEOUT = 2700,
  parameter logic [7:0]  EOL_CHAR     = 8'h0A,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       sys_clk,
  input  logic       rst_sync_n,
  input  logic       req0_valid_i,
  input  logic [7:0] req0_data_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [7:0] req1_data_i,
  output logic       req1_ready_o,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_ready_i,
  output logic [1:0] grant_o
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(IDLE_TIMEOUT);
  localparam bit               TimeoutEn  = (IDLE_TIMEOUT != 0);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic       slot_free;
  logic       acc0, acc1, acc_any;
  logic [7:0] acc_data;

  assign slot_free = ~tx_valid_q | tx_ready_i;
  assign acc0      = req0_ready_o & req0_valid_i;
  assign acc1      = req1_ready_o & req1_valid_i;
  assign acc_any   = acc0 | acc1;
  assign acc_data  = acc1 ? req1_data_i : req0_data_i;

  always_ff @(posedge sys_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    timer_d   = timer_q;
    timer_inc = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        // On a tie the requester that did not own the last line wins.
        if (req0_valid_i && req1_valid_i) begin
          state_d = last_q ? StLock0 : StLock1;
        end else if (req0_valid_i) begin
          state_d = StLock0;
        end else if (req1_valid_i) begin
          state_d = StLock1;
        end
      end
      StLock0, StLock1: begin
        if (acc_any) begin
          timer_d = '0;
          if (acc_data == EOL_CHAR) begin
            state_d = StIdle;
            last_d  = (state_q == StLock1);
          end
        end else begin
          timer_d = timer_inc;
          if (TimeoutEn && (timer_inc >= TimeoutVal)) begin
            state_d = StIdle;
            last_d  = (state_q == StLock1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_o      = 2'b00;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    unique case (state_q)
      StLock0: begin
        grant_o      = 2'b01;
        req0_ready_o = slot_free;
      end
      StLock1: begin
        grant_o      = 2'b10;
        req1_ready_o = slot_free;
      end
      default: ;
    endcase
  end

  // Single-entry output register; data holds until the UART takes it.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (acc_any) begin
      tx_valid_d = 1'b1;
      tx_data_d  = acc_data;
    end else if (tx_ready_i) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_amber128_uart_tx_arb.sv
// Bench for amber128_uart_tx_arb: scoreboard of accepted bytes against the tx stream,
// plus directed checks of grant timing, backpressure, timeout and reset.
module tb_amber128_uart_tx_arb;

  logic       sys_clk = 1'b0;
  logic       rst_sync_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       tx_ready = 1'b0;

  logic       a_rdy0, a_rdy1, a_tx_valid;
  logic [7:0] a_tx_data;
  logic [1:0] a_grant;
  logic       b_rdy0, b_rdy1, b_tx_valid;
  logic [7:0] b_tx_data;
  logic [1:0] b_grant;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [7:0] sb[$];
  logic       en0 = 1'b0, en1 = 1'b0;
  logic       acc0 = 1'b0, acc1 = 1'b0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic [7:0] exp_b, pop_b;

  logic [1:0] t1_g [6];
  logic       t1_v [6];
  logic [1:0] t2_g [7];

  always #5 sys_clk = ~sys_clk;

  amber128_uart_tx_arb #(.IDLE_TIMEOUT(16), .EOL_CHAR(8'h0A), .CNT_W(16)) dut_a (
    .sys_clk      (sys_clk),
    .rst_sync_n   (rst_sync_n),
    .req0_valid_i (req0_valid),
    .req0_data_i  (req0_data),
    .req0_ready_o (a_rdy0),
    .req1_valid_i (req1_valid),
    .req1_data_i  (req1_data),
    .req1_ready_o (a_rdy1),
    .tx_valid_o   (a_tx_valid),
    .tx_data_o    (a_tx_data),
    .tx_ready_i   (tx_ready),
    .grant_o      (a_grant)
  );

  // Never-release variant with a narrow counter so saturation is reached quickly.
  amber128_uart_tx_arb #(.IDLE_TIMEOUT(0), .EOL_CHAR(8'h0A), .CNT_W(4)) dut_b (
    .sys_clk      (sys_clk),
    .rst_sync_n   (rst_sync_n),
    .req0_valid_i (req0_valid),
    .req0_data_i  (req0_data),
    .req0_ready_o (b_rdy0),
    .req1_valid_i (req1_valid),
    .req1_data_i  (req1_data),
    .req1_ready_o (b_rdy1),
    .tx_valid_o   (b_tx_valid),
    .tx_data_o    (b_tx_data),
    .tx_ready_i   (tx_ready),
    .grant_o      (b_grant)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor on dut_a: pop on tx handshake, push on accept, check hold and ownership.
  always @(negedge sys_clk) begin
    if (rst_sync_n) begin
      if (a_tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          chk("tx_unexpected", 1, 0);
        end else begin
          exp_b = sb.pop_front();
          chk("tx_data", a_tx_data, exp_b);
        end
      end
      if (hold_pend) begin
        chk("hold_valid", a_tx_valid, 1);
        chk("hold_data", a_tx_data, hold_data);
      end
      hold_pend = a_tx_valid && !tx_ready;
      hold_data = a_tx_data;
      acc0 = a_rdy0 && req0_valid;
      acc1 = a_rdy1 && req1_valid;
      if (acc0) sb.push_back(req0_data);
      if (acc1) sb.push_back(req1_data);
      chk("grant_onehot", a_grant == 2'b11, 0);
      chk("rdy0_owner", a_rdy0 && (a_grant != 2'b01), 0);
      chk("rdy1_owner", a_rdy1 && (a_grant != 2'b10), 0);
    end else begin
      acc0 = 1'b0;
      acc1 = 1'b0;
      hold_pend = 1'b0;
    end
  end

  // Requester drivers: retire an accepted byte, then present the next one.
  always @(posedge sys_clk) begin
    #2;
    if (acc0 && src0.size() > 0) pop_b = src0.pop_front();
    if (acc1 && src1.size() > 0) pop_b = src1.pop_front();
    acc0 = 1'b0;
    acc1 = 1'b0;
    req0_valid = en0 && (src0.size() > 0);
    req0_data  = (src0.size() > 0) ? src0[0] : 8'h00;
    req1_valid = en1 && (src1.size() > 0);
    req1_data  = (src1.size() > 0) ? src1[0] : 8'h00;
  end

  task automatic do_reset();
    @(posedge sys_clk); #1;
    rst_sync_n = 1'b0;
    en0 = 1'b0;
    en1 = 1'b0;
    tx_ready = 1'b0;
    src0.delete();
    src1.delete();
    sb.delete();
    repeat (2) @(posedge sys_clk);
    #1 rst_sync_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (n < 200 && !(src0.size() == 0 && src1.size() == 0 && sb.size() == 0 && !a_tx_valid)) begin
      @(posedge sys_clk); #3;
      n++;
    end
    chk({tag, "_drain_src"}, src0.size() + src1.size(), 0);
    chk({tag, "_drain_sb"}, sb.size(), 0);
    chk({tag, "_drain_txv"}, a_tx_valid, 0);
    en0 = 1'b0;
    en1 = 1'b0;
  endtask

  initial begin
    bit found;
    t1_g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    t1_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    t2_g = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};

    repeat (3) @(posedge sys_clk);
    #1 rst_sync_n = 1'b1;
    @(negedge sys_clk);
    chk("rst_txv", a_tx_valid, 0);
    chk("rst_txd", a_tx_data, 8'h00);
    chk("rst_grant", a_grant, 2'b00);
    chk("rst_rdy0", a_rdy0, 0);
    chk("rst_rdy1", a_rdy1, 0);
    chk("rst_b_grant", b_grant, 2'b00);

    // T1: "Hi\n" from req0 with an always-ready UART
    @(posedge sys_clk); #1;
    tx_ready = 1'b1;
    src0.push_back(8'h48); src0.push_back(8'h69); src0.push_back(8'h0A);
    en0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      chk("t1_grant", a_grant, t1_g[i]);
      chk("t1_txv", a_tx_valid, t1_v[i]);
    end
    wait_drain("t1");

    // T2: simultaneous lines; req0 wins first after reset
    do_reset();
    @(posedge sys_clk); #1;
    tx_ready = 1'b1;
    src0.push_back(8'h41); src0.push_back(8'h0A);
    src1.push_back(8'h42); src1.push_back(8'h0A);
    en0 = 1'b1;
    en1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge sys_clk);
      chk("t2_grant", a_grant, t2_g[i]);
    end
    wait_drain("t2");

    // T3: 10 cycles of UART backpressure mid-stream
    do_reset();
    @(posedge sys_clk); #1;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) src0.push_back(8'h30 + 8'(i));
    en0 = 1'b1;
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk); #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      chk("t3_rdy0", a_rdy0, 0);
      chk("t3_txv", a_tx_valid, 1);
    end
    @(posedge sys_clk); #1;
    tx_ready = 1'b1;
    wait_drain("t3");

    // T4: req1 goes quiet after "AB"; forced release after 16 idle cycles
    do_reset();
    @(posedge sys_clk); #1;
    tx_ready = 1'b1;
    src1.push_back(8'h41); src1.push_back(8'h42);
    en1 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge sys_clk);
      if (a_rdy1 && req1_valid && req1_data == 8'h42) found = 1'b1;
    end
    chk("t4_b_accept", found, 1);
    @(posedge sys_clk); #1;
    src0.push_back(8'h5A);
    en0 = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge sys_clk);
      if (i <= 16) chk("t4_locked", a_grant, 2'b10);
      else chk("t4_release", a_grant, 2'b00);
    end
    @(negedge sys_clk);
    chk("t4_next_owner", a_grant, 2'b01);
    @(posedge sys_clk); #1;
    src0.push_back(8'h0A);
    wait_drain("t4");

    // T5: never-release instance keeps the lock through a long idle stretch
    do_reset();
    @(posedge sys_clk); #1;
    tx_ready = 1'b1;
    src1.push_back(8'h51);
    en1 = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge sys_clk);
      if (i % 50 == 0) begin
        chk("t5_b_grant", b_grant, 2'b10);
        chk("t5_b_rdy0", b_rdy0, 0);
      end
    end
    chk("t5_b_txv", b_tx_valid, 0);
    wait_drain("t5");

    // T6: finish one req0 line (so req1 would be favoured), then reset mid-line
    do_reset();
    @(posedge sys_clk); #1;
    tx_ready = 1'b1;
    src0.push_back(8'h6B); src0.push_back(8'h0A);
    en0 = 1'b1;
    wait_drain("t6a");
    @(posedge sys_clk); #1;
    tx_ready = 1'b0;
    src0.push_back(8'h78); src0.push_back(8'h79); src0.push_back(8'h7A);
    en0 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge sys_clk);
      if (a_tx_valid) found = 1'b1;
    end
    chk("t6_txv_seen", found, 1);
    @(posedge sys_clk); #1;
    rst_sync_n = 1'b0;
    #1;
    chk("t6_rst_txv", a_tx_valid, 0);
    chk("t6_rst_txd", a_tx_data, 8'h00);
    chk("t6_rst_grant", a_grant, 2'b00);
    chk("t6_rst_rdy0", a_rdy0, 0);
    chk("t6_rst_b_txv", b_tx_valid, 0);
    en0 = 1'b0;
    src0.delete();
    sb.delete();
    repeat (2) @(posedge sys_clk);
    #1 rst_sync_n = 1'b1;
    tx_ready = 1'b1;
    src0.push_back(8'h61); src0.push_back(8'h0A);
    src1.push_back(8'h62); src1.push_back(8'h0A);
    en0 = 1'b1;
    en1 = 1'b1;
    @(negedge sys_clk);
    chk("t6_idle", a_grant, 2'b00);
    @(negedge sys_clk);
    chk("t6_req0_wins", a_grant, 2'b01);
    wait_drain("t6b");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
